// File: rtl/adc_capture_engine.sv
// Multi-channel ADC capture engine: decimation and level trigger, first-word-fall-through FIFO
// streaming to AXI-Stream, control/status behind an AXI4-Lite slave.
module adc_capture_engine #(
   parameter int NUM_CH             = 2,
   parameter int ADC_WIDTH          = 12,
   parameter int LEN_WIDTH          = 20,
   parameter int FIFO_DEPTH         = 16,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]                    s_axi_awprot,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [31:0]                   s_axi_wdata,
   input  logic [3:0]                    s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]                    s_axi_arprot,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [31:0]                   s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_data,
   input  logic                          adc_valid,
   output logic [NUM_CH*16-1:0]          m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          irq
);
   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = NUM_CH*16 + 1;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

   state_t state, state_nxt;
   logic axi_awready, axi_bvalid, axi_arready, axi_rvalid, wr_fire;
   logic [31:0] axi_rdata, rd_mux;
   logic [IW-1:0] wr_idx, rd_idx;
   logic [1:0] trig_mode, trig_ch, mode_new, ch_new, mode_sh, ch_sh;
   logic [LEN_WIDTH-1:0] sample_len, len_sh, frame_cnt;
   logic [15:0] decim, decim_sh, decim_cnt;
   logic [ADC_WIDTH-1:0] trig_level, level_sh, trig_sample, prev_sample;
   logic ctrl_wr, start, abort, prev_ok, trig_hit, done, overflow, busy;
   logic sample_evt, done_set, push, pop, frame_last, fifo_empty, fifo_full;
   logic [NUM_CH*16-1:0] frame;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr, fifo_count;
   logic [3:0] level4;
   logic unused_bits;

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
      return r;
   endfunction

   assign s_axi_awready = axi_awready;
   assign s_axi_wready  = axi_awready;
   assign s_axi_bvalid  = axi_bvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = axi_arready;
   assign s_axi_rvalid  = axi_rvalid;
   assign s_axi_rdata   = axi_rdata;
   assign s_axi_rresp   = 2'b00;

   assign wr_fire  = axi_awready && s_axi_awvalid && s_axi_wvalid;
   assign wr_idx   = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_idx   = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign ctrl_wr  = wr_fire && (wr_idx == IW'(0)) && s_axi_wstrb[0];
   assign abort    = ctrl_wr && s_axi_wdata[1];
   assign start    = ctrl_wr && s_axi_wdata[0] && !s_axi_wdata[1] && (state == IDLE);
   assign mode_new = ctrl_wr ? s_axi_wdata[3:2] : trig_mode;
   assign ch_new   = ctrl_wr ? s_axi_wdata[5:4] : trig_ch;
   assign busy     = (state != IDLE);

   // One transaction in flight per direction: a new address phase waits for the response handshake.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         axi_awready <= 1'b0;
         axi_bvalid  <= 1'b0;
         axi_arready <= 1'b0;
         axi_rvalid  <= 1'b0;
         axi_rdata   <= '0;
      end else begin
         axi_awready <= s_axi_awvalid && s_axi_wvalid && !axi_awready && !axi_bvalid;
         if (wr_fire) axi_bvalid <= 1'b1;
         else if (s_axi_bready) axi_bvalid <= 1'b0;
         axi_arready <= s_axi_arvalid && !axi_arready && !axi_rvalid;
         if (axi_arready) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_mux;
         end else if (s_axi_rready) begin
            axi_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         trig_mode  <= '0;
         trig_ch    <= '0;
         sample_len <= '0;
         decim      <= '0;
         trig_level <= '0;
      end else if (wr_fire) begin
         case (wr_idx)
            IW'(0): if (s_axi_wstrb[0]) begin
               trig_mode <= s_axi_wdata[3:2];
               trig_ch   <= s_axi_wdata[5:4];
            end
            IW'(1): sample_len <= LEN_WIDTH'(merge(32'(sample_len), s_axi_wdata, s_axi_wstrb));
            IW'(2): decim      <= 16'(merge(32'(decim), s_axi_wdata, s_axi_wstrb));
            IW'(3): trig_level <= ADC_WIDTH'(merge(32'(trig_level), s_axi_wdata, s_axi_wstrb));
            default: ;
         endcase
      end
   end

   always_comb begin
      level4 = 4'(fifo_count);
      case (rd_idx)
         IW'(0):  rd_mux = {26'd0, trig_ch, trig_mode, 2'b00};
         IW'(1):  rd_mux = 32'(sample_len);
         IW'(2):  rd_mux = {16'd0, decim};
         IW'(3):  rd_mux = 32'(trig_level);
         IW'(4):  rd_mux = {24'd0, level4, 1'b0, overflow, done, busy};
         default: rd_mux = '0;
      endcase
   end

   always_comb begin
      frame       = '0;
      trig_sample = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         frame[c*16 +: 16] = 16'(adc_data[c*ADC_WIDTH +: ADC_WIDTH]);
         if (ch_sh == 2'(c)) trig_sample = adc_data[c*ADC_WIDTH +: ADC_WIDTH];
      end
   end

   assign trig_hit = (state == ARM) && adc_valid && prev_ok &&
      (((mode_sh == 2'd1) && (prev_sample < level_sh) && (trig_sample >= level_sh)) ||
       ((mode_sh == 2'd2) && (prev_sample >= level_sh) && (trig_sample < level_sh)));

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && (sample_len != '0))
                     state_nxt = ((mode_new == 2'd1) || (mode_new == 2'd2)) ? ARM : CAPTURE;
         ARM:     if (sample_evt) state_nxt = (push && frame_last) ? DRAIN : CAPTURE;
         CAPTURE: if (push && frame_last) state_nxt = DRAIN;
         DRAIN:   if (fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_comb begin
      sample_evt = 1'b0;
      done_set   = 1'b0;
      case (state)
         IDLE:    done_set   = start && (sample_len == '0);
         ARM:     sample_evt = trig_hit;
         CAPTURE: sample_evt = adc_valid && (decim_cnt == 16'd0);
         DRAIN:   done_set   = fifo_empty;
         default: ;
      endcase
      if (abort) begin
         sample_evt = 1'b0;
         done_set   = 1'b0;
      end
   end

   assign pop        = m_axis_tvalid && m_axis_tready;
   assign push       = sample_evt && (!fifo_full || pop);
   assign frame_last = (frame_cnt == len_sh - LEN_WIDTH'(1));

   // Capture parameters are shadowed at START so register writes mid-capture wait for the next run.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         mode_sh <= '0; ch_sh <= '0; len_sh <= '0; decim_sh <= '0; level_sh <= '0;
         frame_cnt <= '0; decim_cnt <= '0; prev_sample <= '0; prev_ok <= 1'b0;
         done <= 1'b0; overflow <= 1'b0; irq <= 1'b0;
      end else begin
         irq <= done_set;
         if (adc_valid) prev_sample <= trig_sample;
         if (done_set) done <= 1'b1;
         else if (start) done <= 1'b0;
         if (start) begin
            mode_sh   <= mode_new;
            ch_sh     <= ch_new;
            len_sh    <= sample_len;
            decim_sh  <= decim;
            level_sh  <= trig_level;
            frame_cnt <= '0;
            decim_cnt <= '0;
            prev_ok   <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            if ((state == ARM) && adc_valid) prev_ok <= 1'b1;
            if (((state == CAPTURE) && adc_valid) || trig_hit)
               decim_cnt <= (decim_cnt == decim_sh) ? 16'd0 : decim_cnt + 16'd1;
            if (push) frame_cnt <= frame_cnt + LEN_WIDTH'(1);
            if (sample_evt && !push) overflow <= 1'b1;
         end
      end
   end

   assign fifo_count    = wr_ptr - rd_ptr;
   assign fifo_empty    = (fifo_count == '0);
   assign fifo_full     = fifo_count[PW];
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = mem[rd_ptr[PW-1:0]][EW-2:0];
   assign m_axis_tlast  = !fifo_empty && mem[rd_ptr[PW-1:0]][EW-1];

   always_ff @(posedge ACLK) begin
      if (push) mem[wr_ptr[PW-1:0]] <= {frame_last, frame};
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end
endmodule

// File: tb/tb_adc_capture_engine.sv
// Directed bench for adc_capture_engine: register access, immediate/decimated/triggered capture,
// FIFO backpressure with overflow, and abort/restart.
module tb_adc_capture_engine;
   localparam int NUM_CH = 2, ADC_WIDTH = 12, LEN_WIDTH = 20, FIFO_DEPTH = 4, AW = 5;

   logic ACLK = 1'b0, ARESETN = 1'b0;
   logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
   logic [2:0] s_axi_awprot, s_axi_arprot;
   logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
   logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
   logic [31:0] s_axi_wdata, s_axi_rdata;
   logic [3:0] s_axi_wstrb;
   logic [1:0] s_axi_bresp, s_axi_rresp;
   logic [NUM_CH*ADC_WIDTH-1:0] adc_data;
   logic adc_valid;
   logic [NUM_CH*16-1:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tready, m_axis_tlast, irq;

   int vectors = 0, miscompares = 0, irqCount = 0;
   logic [32:0] beats[$];
   logic [31:0] expData[8];
   logic [31:0] rd;

   adc_capture_engine #(.NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH), .LEN_WIDTH(LEN_WIDTH),
                        .FIFO_DEPTH(FIFO_DEPTH), .C_S_AXI_ADDR_WIDTH(AW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .adc_data(adc_data), .adc_valid(adc_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .irq(irq)
   );

   always #5 ACLK = ~ACLK;

   // Stream beats and irq pulses are collected away from the active edge.
   always @(negedge ACLK) begin
      if (ARESETN && m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
      if (irq) irqCount++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic axiWrite(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(posedge ACLK); #1;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!s_axi_awready && n < 20);
      if (!s_axi_awready) checkOutput("awready_timeout", 0, 1);
      @(posedge ACLK); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n = 0;
      while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
      if (!s_axi_bvalid) checkOutput("bvalid_timeout", 0, 1);
      @(posedge ACLK); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic axiRead(input logic [AW-1:0] a, output logic [31:0] d);
      int n;
      @(posedge ACLK); #1;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end while (!s_axi_arready && n < 20);
      if (!s_axi_arready) checkOutput("arready_timeout", 0, 1);
      @(posedge ACLK); #1;
      s_axi_arvalid = 1'b0;
      n = 0;
      while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
      if (!s_axi_rvalid) checkOutput("rvalid_timeout", 0, 1);
      d = s_axi_rdata;
      @(posedge ACLK); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [11:0] ch0, input logic [11:0] ch1, input logic valid);
      @(posedge ACLK); #1;
      adc_data = {ch1, ch0};
      adc_valid = valid;
   endtask

   task automatic checkStream(input string name, input int n, input bit lastOnFinal);
      checkOutput({name, "_count"}, 64'(beats.size()), 64'(n));
      for (int i = 0; i < n && i < beats.size(); i++) begin
         checkOutput($sformatf("%s_data%0d", name, i), 64'(beats[i][31:0]), 64'(expData[i]));
         checkOutput($sformatf("%s_last%0d", name, i), 64'(beats[i][32]), 64'(lastOnFinal && i == n-1));
      end
   endtask

   task automatic clearLog();
      beats.delete();
      irqCount = 0;
   endtask

   initial begin
      s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_awprot = '0; s_axi_arprot = '0;
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
      s_axi_wdata = '0; s_axi_wstrb = '0; adc_data = '0; adc_valid = 0; m_axis_tready = 0;

      repeat (2) @(negedge ACLK);
      checkOutput("rst_awready", s_axi_awready, 0);
      checkOutput("rst_wready", s_axi_wready, 0);
      checkOutput("rst_bvalid", s_axi_bvalid, 0);
      checkOutput("rst_arready", s_axi_arready, 0);
      checkOutput("rst_rvalid", s_axi_rvalid, 0);
      checkOutput("rst_tvalid", m_axis_tvalid, 0);
      checkOutput("rst_tlast", m_axis_tlast, 0);
      checkOutput("rst_irq", irq, 0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;

      $display("[TB] register read/write");
      axiRead(5'h10, rd);  checkOutput("status_reset", rd, 32'h0);
      axiWrite(5'h0C, 32'hABC, 4'hF);
      axiWrite(5'h08, 32'h3, 4'hF);
      axiWrite(5'h04, 32'h10, 4'hF);
      axiRead(5'h0C, rd);  checkOutput("rd_level", rd, 32'hABC);
      axiRead(5'h08, rd);  checkOutput("rd_decim", rd, 32'h3);
      axiRead(5'h04, rd);  checkOutput("rd_len", rd, 32'h10);
      axiRead(5'h14, rd);  checkOutput("rd_unmapped", rd, 32'h0);
      axiWrite(5'h08, 32'hFFFF_5577, 4'b0010);
      axiRead(5'h08, rd);  checkOutput("rd_decim_strb", rd, 32'h5503);
      axiWrite(5'h00, 32'h3C, 4'hF);
      axiRead(5'h00, rd);  checkOutput("rd_ctrl", rd, 32'h3C);
      axiRead(5'h10, rd);  checkOutput("status_idle", rd, 32'h0);

      $display("[TB] immediate capture");
      clearLog();
      m_axis_tready = 1'b1;
      axiWrite(5'h04, 32'd4, 4'hF);
      axiWrite(5'h08, 32'd0, 4'hF);
      axiWrite(5'h00, 32'h1, 4'hF);
      applyStimulus(12'h000, 12'hFFF, 1);
      @(negedge ACLK); checkOutput("latency_pre", m_axis_tvalid, 0);
      applyStimulus(12'h001, 12'hFFE, 1);
      @(negedge ACLK); checkOutput("latency_post", m_axis_tvalid, 1);
      applyStimulus(12'h002, 12'hFFD, 1);
      applyStimulus(12'h003, 12'hFFC, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (8) @(posedge ACLK);
      expData[0] = 32'h0FFF_0000; expData[1] = 32'h0FFE_0001;
      expData[2] = 32'h0FFD_0002; expData[3] = 32'h0FFC_0003;
      checkStream("imm", 4, 1);
      checkOutput("imm_irq", irqCount, 1);
      axiRead(5'h10, rd);  checkOutput("imm_status", rd, 32'h2);

      $display("[TB] decimation");
      clearLog();
      axiWrite(5'h08, 32'd2, 4'hF);
      axiWrite(5'h04, 32'd3, 4'hF);
      axiWrite(5'h00, 32'h1, 4'hF);
      for (int n = 0; n < 9; n++) applyStimulus(12'(n), 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (8) @(posedge ACLK);
      expData[0] = 32'h0; expData[1] = 32'h3; expData[2] = 32'h6;
      checkStream("decim", 3, 1);
      checkOutput("decim_irq", irqCount, 1);

      $display("[TB] rising trigger");
      clearLog();
      axiWrite(5'h08, 32'd0, 4'hF);
      axiWrite(5'h04, 32'd2, 4'hF);
      axiWrite(5'h0C, 32'h800, 4'hF);
      axiWrite(5'h00, 32'h5, 4'hF);
      applyStimulus(12'h7F0, 12'h000, 1);
      applyStimulus(12'h7FF, 12'h000, 1);
      applyStimulus(12'h800, 12'h000, 1);
      applyStimulus(12'h810, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (8) @(posedge ACLK);
      expData[0] = 32'h800; expData[1] = 32'h810;
      checkStream("rise", 2, 1);
      axiRead(5'h10, rd);  checkOutput("rise_status", rd, 32'h2);

      $display("[TB] falling trigger, same data");
      clearLog();
      axiWrite(5'h00, 32'h9, 4'hF);
      applyStimulus(12'h7F0, 12'h000, 1);
      applyStimulus(12'h7FF, 12'h000, 1);
      applyStimulus(12'h800, 12'h000, 1);
      applyStimulus(12'h810, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (8) @(posedge ACLK);
      checkOutput("fall_beats", beats.size(), 0);
      axiRead(5'h10, rd);  checkOutput("fall_status_busy", rd, 32'h1);
      axiWrite(5'h00, 32'h2, 4'hF);
      axiRead(5'h10, rd);  checkOutput("fall_status_aborted", rd, 32'h0);
      checkOutput("fall_irq", irqCount, 0);

      $display("[TB] backpressure");
      clearLog();
      m_axis_tready = 1'b0;
      axiWrite(5'h04, 32'd8, 4'hF);
      axiWrite(5'h00, 32'h1, 4'hF);
      for (int n = 0; n < 10; n++) applyStimulus(12'(n), 12'h0AA, 1);
      applyStimulus(12'h000, 12'h000, 0);
      axiRead(5'h10, rd);  checkOutput("bp_status_full", rd, 32'h45);
      @(posedge ACLK); #1;
      m_axis_tready = 1'b1;
      for (int n = 10; n < 14; n++) applyStimulus(12'(n), 12'h0AA, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (10) @(posedge ACLK);
      expData[0] = 32'h00AA_0000; expData[1] = 32'h00AA_0001;
      expData[2] = 32'h00AA_0002; expData[3] = 32'h00AA_0003;
      expData[4] = 32'h00AA_000A; expData[5] = 32'h00AA_000B;
      expData[6] = 32'h00AA_000C; expData[7] = 32'h00AA_000D;
      checkStream("bp", 8, 1);
      checkOutput("bp_irq", irqCount, 1);
      axiRead(5'h10, rd);  checkOutput("bp_status_done", rd, 32'h6);

      $display("[TB] abort and restart");
      clearLog();
      axiWrite(5'h04, 32'd100, 4'hF);
      axiWrite(5'h00, 32'h1, 4'hF);
      applyStimulus(12'h000, 12'h000, 1);
      applyStimulus(12'h001, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      @(posedge ACLK); #1;
      m_axis_tready = 1'b0;
      applyStimulus(12'h002, 12'h000, 1);
      applyStimulus(12'h003, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      @(negedge ACLK); checkOutput("abort_tvalid_before", m_axis_tvalid, 1);
      axiWrite(5'h00, 32'h3, 4'hF);
      @(negedge ACLK); checkOutput("abort_tvalid_after", m_axis_tvalid, 0);
      axiRead(5'h10, rd);  checkOutput("abort_status", rd, 32'h0);
      expData[0] = 32'h0; expData[1] = 32'h1;
      checkStream("abort", 2, 0);
      checkOutput("abort_irq", irqCount, 0);

      clearLog();
      m_axis_tready = 1'b1;
      axiWrite(5'h04, 32'd2, 4'hF);
      axiWrite(5'h00, 32'h1, 4'hF);
      applyStimulus(12'h020, 12'h000, 1);
      applyStimulus(12'h021, 12'h000, 1);
      applyStimulus(12'h000, 12'h000, 0);
      repeat (8) @(posedge ACLK);
      expData[0] = 32'h20; expData[1] = 32'h21;
      checkStream("restart", 2, 1);
      checkOutput("restart_irq", irqCount, 1);
      axiRead(5'h10, rd);  checkOutput("restart_status", rd, 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
